// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, set wins on a tie.
// Register 0 is never marked busy.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic [1:0]      wr_en,
  input  logic [2*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]  rd_busy,
  output logic            busy_any
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state: clear on writeback first, then issue overrides.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) begin
        busy_d[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port busy lookup and drain indicator.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
    end
    busy_any = |busy_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports
// (WB0 = ALU, WB1 = load; WB1 wins on an address collision) and a busy scoreboard.
// Optional macro REGFILE_MP_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = NRD_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*XLEN-1:0] wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic              busy_any
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NRD-1:0]  sb_busy;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy),
    .busy_any (busy_any)
  );

  // Data array; WB1 is applied after WB0 so it wins on a shared address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != Zero)) begin
          regs_q[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports, forced to zero while reset is held.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      a = rd_addr[i*AW +: AW];
      d = (a == Zero) ? '0 : regs_q[a];
      b = sb_busy[i];
`ifdef REGFILE_MP_BYPASS_EN
      // Forwarded value is final, so it is not busy unless re-issued right now.
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != Zero) && (wr_addr[k*AW +: AW] == a)) begin
          d = wr_data[k*XLEN +: XLEN];
          b = iss_en && (iss_rd == a);
        end
      end
`endif
      rd_data[i*XLEN +: XLEN] = rst ? d : '0;
      rd_busy[i]              = rst & b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD = 4) against a behavioural model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [1:0]           wr_en;
  logic [2*AW-1:0]      wr_addr;
  logic [2*XLEN-1:0]    wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_rd;
  logic                 busy_any;

  int vectors;
  int miscompares;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy_any (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  end

  // Model: architectural state update on each edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        int a;
        a = int'(wr_addr[k*AW +: AW]);
        if (wr_en[k] && a != 0) begin
          m_regs[a] = wr_data[k*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (iss_en && iss_rd != 0) m_busy[int'(iss_rd)] = 1'b1;
    end
  end

  always @(negedge rst) begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(int p);
    int a;
    logic [XLEN-1:0] v;
    a = int'(rd_addr[p*AW +: AW]);
    if (rst !== 1'b1 || a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_MP_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) v = wr_data[k*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(int p);
    int a;
    logic b;
    a = int'(rd_addr[p*AW +: AW]);
    if (rst !== 1'b1 || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) b = iss_en && (int'(iss_rd) == a);
`endif
    return b;
  endfunction

  function automatic logic exp_any();
    logic b;
    b = 1'b0;
    for (int r = 1; r < NREGS; r++) b = b | m_busy[r];
    return b;
  endfunction

  // Compare process: every falling edge, all ports against the model.
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      vectors++;
      if (rd_data[p*XLEN +: XLEN] !== exp_data(p)) begin
        miscompares++;
        $display("FAIL model rd_data[%0d] got %h exp %h at %0t", p, rd_data[p*XLEN +: XLEN],
                 exp_data(p), $time);
      end
      vectors++;
      if (rd_busy[p] !== exp_busy(p)) begin
        miscompares++;
        $display("FAIL model rd_busy[%0d] got %b exp %b at %0t", p, rd_busy[p], exp_busy(p),
                 $time);
      end
    end
    vectors++;
    if (busy_any !== exp_any()) begin
      miscompares++;
      $display("FAIL model busy_any got %b exp %b at %0t", busy_any, exp_any(), $time);
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input logic [1:0] en, input int a0, input logic [XLEN-1:0] d0,
                        input int a1, input logic [XLEN-1:0] d1);
    wr_en   = en;
    wr_addr = {AW'(a1), AW'(a0)};
    wr_data = {d1, d0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    iss_en  = 1'b0;
    iss_rd  = '0;
    rd_addr = '0;
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); set_rd(3, 0);

    // 1: reset held with both write ports hammering.
    set_wr(2'b11, 1, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
    iss_en = 1'b1; iss_rd = 5'd3;
    tick(); tick();
    chk("reset_hold_x1", rd_data[0 +: XLEN], 32'h0);
    rst = 1'b1;
    set_wr(2'b00, 0, 0, 0, 0);
    iss_en = 1'b0;
    @(negedge clk);
    chk("rst_x1", rd_data[0 +: XLEN], 32'h0);
    chk("rst_x2", rd_data[XLEN +: XLEN], 32'h0);
    chk("rst_busy", {28'h0, rd_busy}, 32'h0);
    chk("rst_any", {31'h0, busy_any}, 32'h0);

    // 2: WB1 wins on collision; x0 ignores writes.
    tick();
    set_wr(2'b11, 1, 32'hDEADBEEF, 1, 32'hCAFEBABE);
    tick();
    set_wr(2'b01, 0, 32'h12345678, 0, 0);
    set_rd(1, 0);
    @(negedge clk);
    chk("wb1_wins_x1", rd_data[0 +: XLEN], 32'hCAFEBABE);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_zero", rd_data[XLEN +: XLEN], 32'h0);

    // 3: issue x5, writeback three cycles later on WB1.
    tick();
    set_rd(0, 5);
    iss_en = 1'b1; iss_rd = 5'd5;
    tick();
    iss_en = 1'b0;
    @(negedge clk);
    chk("x5_busy", {31'h0, rd_busy[0]}, 32'h1);
    chk("x5_any", {31'h0, busy_any}, 32'h1);
    tick(); tick();
    set_wr(2'b10, 0, 0, 5, 32'hAAAAAAAA);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("x5_clr_busy", {31'h0, rd_busy[0]}, 32'h0);
    chk("x5_data", rd_data[0 +: XLEN], 32'hAAAAAAAA);
    chk("x5_any_clr", {31'h0, busy_any}, 32'h0);

    // 4: same-cycle issue and writeback: set wins.
    tick();
    set_rd(0, 7);
    iss_en = 1'b1; iss_rd = 5'd7;
    set_wr(2'b01, 7, 32'h55555555, 0, 0);
    tick();
    iss_en = 1'b0;
    set_wr(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("x7_data", rd_data[0 +: XLEN], 32'h55555555);
    chk("x7_busy", {31'h0, rd_busy[0]}, 32'h1);
    tick();
    set_wr(2'b01, 7, 32'h55555555, 0, 0);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);

    // 5: same-cycle write/read of x4.
    set_wr(2'b01, 4, 32'h00000001, 0, 0);
    tick();
    set_rd(0, 4);
    set_wr(2'b01, 4, 32'h0BADF00D, 0, 0);
    @(negedge clk);
`ifdef REGFILE_MP_BYPASS_EN
    chk("x4_same_cycle", rd_data[0 +: XLEN], 32'h0BADF00D);
`else
    chk("x4_same_cycle", rd_data[0 +: XLEN], 32'h00000001);
`endif
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("x4_next_cycle", rd_data[0 +: XLEN], 32'h0BADF00D);

    // 6: four distinct ports, then asynchronous reset mid-cycle with x3 busy.
    tick();
    set_wr(2'b01, 3, 32'h11111111, 0, 0);
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    iss_en = 1'b0;
    set_rd(0, 1); set_rd(1, 3); set_rd(2, 5); set_rd(3, 7);
    @(negedge clk);
    chk("p0_x1", rd_data[0 +: XLEN], 32'hCAFEBABE);
    chk("p1_x3", rd_data[XLEN +: XLEN], 32'h11111111);
    chk("p2_x5", rd_data[2*XLEN +: XLEN], 32'hAAAAAAAA);
    chk("p3_x7", rd_data[3*XLEN +: XLEN], 32'h55555555);
    chk("p_busy", {28'h0, rd_busy}, 32'h2);
    tick();
    #1;
    rst = 1'b0;
    #1;
    chk("async_data", rd_data[XLEN +: XLEN], 32'h0);
    chk("async_busy", {28'h0, rd_busy}, 32'h0);
    chk("async_any", {31'h0, busy_any}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_x3", rd_data[XLEN +: XLEN], 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the single-write, dual-read integer register file, for the pipelined core.
- NRD asynchronous read ports and two synchronous write ports (WB0 = ALU, WB1 = load/long-latency), each with a write enable.
- Per-register busy scoreboard: issue marks a destination pending; writeback clears it.
- Register 0 reads as zero and is never written or marked busy.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
AW, $clog2(NREGS), register address width (derived, not overridable)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-low
rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
rd_busy  out  NRD  1 = addressed register has an outstanding writeback
wr_en  in  2  write enables, bit0 = WB0, bit1 = WB1
wr_addr  in  2*AW  write addresses, WB1 at upper AW bits
wr_data  in  2*XLEN  write data, WB1 at upper XLEN bits
iss_en  in  1  issue strobe: mark iss_rd busy
iss_rd  in  AW  destination register of issuing instruction
busy_any  out  1  OR of all busy bits (pipeline drain indicator)

Behaviour:
- Reset (rst=0): asynchronous.
  - All registers and busy bits clear to 0 immediately, including mid-write.
  - rd_data = 0, rd_busy = 0, busy_any = 0 while reset is held.
- Reads are combinational, zero latency.
  - rd_data[i] = regs[rd_addr[i]].
  - Address 0 always returns 0 and rd_busy = 0.
- Writes take effect on the rising clk edge when wr_en[k]=1 and wr_addr[k]!=0.
  - Without bypass, a same-cycle read returns the old value; the new value is visible from the next cycle.
- Both write ports to the same non-zero address in one cycle: WB1 wins; WB0 data is discarded.
- Scoreboard, evaluated on each rising edge:
  - Set busy[iss_rd] when iss_en=1 and iss_rd!=0.
  - Clear busy[wr_addr[k]] for each enabled write with non-zero address.
  - Same-cycle issue and writeback to the same register: set wins, so busy stays 1 for the new producer.
  - Issue to an already-busy register (WAW): busy stays 1, no error.
  - A writeback to a non-busy register is legal: data is written, busy stays 0.
- busy_any is registered-state derived and combinational from the busy bits; it has no extra latency.
- Writes are accepted with no handshake and no stall; hazard checking is the issue stage's job, using rd_busy.
- All port arithmetic is unsigned index arithmetic.
- Out-of-range addresses cannot occur because NREGS = 2^AW.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- When defined: write-to-read forwarding.
  - If rd_addr[i] matches an enabled, non-zero wr_addr[k] in the current cycle, rd_data[i] = wr_data[k]; WB1 has priority over WB0.
  - rd_busy[i] reads 0 for that register, unless iss_en targets the same register this cycle.
- When undefined: pure array read, as described in Behaviour; no combinational path from wr_* to rd_*.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF, NREGS_DEF, NRD_DEF defaults
  - typedef reg_addr_t (AW bits)
  - typedef xword_t (XLEN bits)
  - constant REG_ZERO = 0
- One sub-module, regfile_scoreboard: NREGS busy bits with set/clear/priority logic, the NRD busy lookups and busy_any.
- The data array, write muxing and bypass stay in regfile_mp.

Test Plan:
1. Hold rst=0 for 2 cycles with wr_en=2'b11 and data 32'hFFFFFFFF on both ports; release; read x1, x2 -> rd_data = 0, rd_busy = 0, busy_any = 0.
2. WB0 writes x1=32'hDEADBEEF while WB1 writes x1=32'hCAFEBABE in the same cycle -> next cycle x1 reads 32'hCAFEBABE. A write of 32'h12345678 to x0 -> x0 reads 0.
3. Issue x5; busy_any=1 and rd_busy=1 on the port reading x5; 3 cycles later WB1 writes x5=32'hAAAAAAAA -> next cycle rd_busy=0, data 32'hAAAAAAAA, busy_any=0.
4. Same cycle: iss_en to x7 and WB0 write to x7 = 32'h55555555 -> next cycle x7 = 32'h55555555 and rd_busy stays 1.
5. Bypass:
   - With REGFILE_MP_BYPASS_EN defined: same-cycle write x4=32'h0BADF00D and read x4 -> rd_data = 32'h0BADF00D in that cycle.
   - Undefined: rd_data shows the old value, then 32'h0BADF00D next cycle.
6. Assert rst=0 asynchronously mid-cycle while x3=32'h11111111 is busy -> rd_data and rd_busy drop to 0 before the next clk edge. With NRD=4, all four ports read distinct registers correctly.
